ccff_bitstream_loader: RTL and testbench
========================================

// Module: ccff_bitstream_loader
// PURPOSE
//  Configuration-chain loader feeding ccff_head of the first tile (cbx/cby/sb/grid chain).
//  Accepts bitstream bytes over a valid/ready port, serialises them MSB-first onto ccff_head,
//  and raises ccff_shift_en for exactly CHAIN_LEN cycles per load.
//  The fabric prog_clk gate uses ccff_shift_en, so chain flops advance only when a bit is presented.
// PARAMETERS
//  CHAIN_LEN  1024                    total config bits in the chain (>=1, need not be a multiple of 8)
//  CNT_W      $clog2(CHAIN_LEN+1)     width of the bit counter
// PORTS
//  prog_clk       in   1      programming clock; all state on rising edge
//  pReset         in   1      asynchronous, active-low reset
//  start          in   1      1-cycle request to begin a load; honoured only in IDLE or DONE
//  abort          in   1      return to IDLE immediately; chain contents undefined afterwards
//  din            in   8      bitstream byte; bit 7 is shifted first
//  din_valid      in   1      din holds a valid byte
//  din_ready      out  1      loader accepts din this cycle (transfer = din_valid & din_ready)
//  ccff_head      out  1      serial config bit to chain head
//  ccff_shift_en  out  1      clock-gate enable for fabric prog_clk; 1 = chain shifts this cycle
//  busy           out  1      state is LOAD or SHIFT
//  cfg_done       out  1      level; exactly CHAIN_LEN bits shifted since last start
//  bits_left      out  CNT_W  config bits still to shift
// BEHAVIOUR
//  Reset (pReset=0, asynchronous): state IDLE.
//   Outputs: din_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, cfg_done=0, bits_left=0.
//  States:
//   IDLE --start--> LOAD (bits_left<=CHAIN_LEN, cfg_done<=0)
//   DONE --start--> LOAD (same)
//   LOAD: din_ready=1, ccff_shift_en=0. On transfer:
//    - shreg<=din
//    - nbits<=min(8,bits_left)
//    - go to SHIFT
//   SHIFT: ccff_head=shreg[7], ccff_shift_en=1. Each cycle:
//    - shreg<<=1
//    - nbits--
//    - bits_left--
//  Last SHIFT cycle (nbits==1):
//   - bits_left becomes 0 -> DONE (cfg_done=1, din_ready=0).
//   - Otherwise din_ready=1 in that same cycle. A transfer reloads shreg and stays in SHIFT (gapless);
//     no transfer -> LOAD.
//  Latency: byte accepted in cycle N; its first bit is on ccff_head with shift_en=1 in cycle N+1.
//   Back-to-back bytes: 8 bits/8 cycles, no bubble.
//  Partial final byte (CHAIN_LEN%8=r!=0): only bits 7..8-r of the last byte are shifted; the rest is discarded.
//  ccff_head, ccff_shift_en: registered outputs (glitch-free gate enable).
//   ccff_head=0 whenever shift_en=0.
//  DONE: din_ready=0; further din ignored; cfg_done held until start or abort.
//  start while busy: ignored. abort has priority over start and transfer:
//   next cycle IDLE, shift_en=0, cfg_done=0, bits_left=0.
//  din_valid low mid-load: stay in LOAD with shift_en=0 indefinitely; no timeout.
//  bits_left never underflows; shift_en is never 1 when bits_left==0.
// STRUCTURE
//  Shared package ccff_pkg:
//   - state enum {IDLE, LOAD, SHIFT, DONE}
//   - localparam BYTE_W=8
//  One sub-module: ccff_byte_serializer
//   - 8-bit shreg plus nbits counter; load/advance inputs, last_bit output.
//   - FSM and bits_left counter stay in the top.
// TESTING
//  1. CHAIN_LEN=16; start, bytes 0xA5, 0x3C with valid held high.
//     -> ccff_head sequence 1010_0101_0011_1100; shift_en high 16 consecutive cycles; cfg_done in cycle 17.
//  2. CHAIN_LEN=12; bytes 0xFF, 0xF0.
//     -> exactly 12 shift cycles, all head=1; low nibble of the 2nd byte dropped; din_ready=0 in DONE.
//  3. CHAIN_LEN=16; din_valid drops for 5 cycles between bytes.
//     -> shift_en=0 and head=0 for the gap; total shift_en count still 16; data unchanged.
//  4. abort asserted after 5 shifted bits.
//     -> next cycle IDLE, shift_en=0, bits_left=0, cfg_done=0; new start reloads bits_left=CHAIN_LEN.
//  5. pReset pulsed low mid-SHIFT, asynchronously between edges.
//     -> all outputs 0 immediately; start ignored while pReset=0.
//  6. start pulsed during SHIFT and again in DONE.
//     -> first ignored (bits_left unaffected); second clears cfg_done and reopens LOAD.

Source files
------------

// File: rtl/ccff_bitstream_loader_pkg.sv
// ccff_pkg: shared loader state encoding and byte-width constants
//   state_t : loader FSM states
//   BYTE_W  : bitstream byte width
//   NB_W    : width of a per-byte bit counter (0..BYTE_W)
package ccff_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
   localparam int BYTE_W = 8;
   localparam int NB_W = $clog2(BYTE_W + 1);
endpackage

// File: rtl/ccff_bitstream_loader_if.sv
// ccff_bitstream_loader_if: byte input port, chain head outputs and status of the loader
//   start/abort          : control requests
//   din/din_valid/ready  : bitstream byte handshake
//   ccff_head/shift_en   : serial bit and clock-gate enable for the chain
//   busy/cfg_done        : status
//   bits_left            : config bits still to shift
interface ccff_bitstream_loader_if #(parameter int CNT_W = 11);
   import ccff_pkg::*;
   logic start;
   logic abort;
   logic [BYTE_W-1:0] din;
   logic din_valid;
   logic din_ready;
   logic ccff_head;
   logic ccff_shift_en;
   logic busy;
   logic cfg_done;
   logic [CNT_W-1:0] bits_left;
   modport master(
      output start, abort, din, din_valid,
      input  din_ready, ccff_head, ccff_shift_en, busy, cfg_done, bits_left
   );
   modport slave(
      input  start, abort, din, din_valid,
      output din_ready, ccff_head, ccff_shift_en, busy, cfg_done, bits_left
   );
endinterface

// File: rtl/ccff_byte_serializer.sv
// ccff_byte_serializer: MSB-first byte shift register with a count of bits still to present
//   prog_clk, pReset : clock, async active-low reset
//   i_clear          : drop any held byte (highest priority)
//   i_load           : capture i_din with i_nbits valid bits (wins over i_advance)
//   i_advance        : the current head bit has been shifted into the chain
//   o_head           : current head bit (flop output, 0 when nothing is held)
//   o_last           : the head bit is the last valid bit of the held byte
module ccff_byte_serializer
   import ccff_pkg::*;
(
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              i_clear,
   input  logic              i_load,
   input  logic              i_advance,
   input  logic [BYTE_W-1:0] i_din,
   input  logic [NB_W-1:0]   i_nbits,
   output logic              o_head,
   output logic              o_last
);
   logic [BYTE_W-1:0] r_shreg;
   logic [NB_W-1:0]   r_nbits;
   // Zeroing on the last bit keeps the head flop at 0 whenever nothing is shifting,
   // which also discards the unused tail of a partial final byte.
   always_ff @(posedge prog_clk or negedge pReset)
      if (!pReset) begin
         r_shreg <= '0;
         r_nbits <= '0;
      end else if (i_clear) begin
         r_shreg <= '0;
         r_nbits <= '0;
      end else if (i_load) begin
         r_shreg <= i_din;
         r_nbits <= i_nbits;
      end else if (i_advance) begin
         r_shreg <= o_last ? '0 : r_shreg << 1;
         r_nbits <= r_nbits - NB_W'(1);
      end
   assign o_head = r_shreg[BYTE_W-1];
   assign o_last = r_nbits == NB_W'(1);
endmodule

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: serialises bitstream bytes MSB-first onto the config chain head
//   prog_clk : programming clock
//   pReset   : asynchronous active-low reset
//   bus      : slave side of ccff_bitstream_loader_if (control, byte handshake, chain outputs, status)
module ccff_bitstream_loader
   import ccff_pkg::*;
#(
   parameter int CHAIN_LEN = 1024,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input logic prog_clk,
   input logic pReset,
   ccff_bitstream_loader_if.slave bus
);
   state_t           r_state;
   state_t           w_state_nx;
   logic [CNT_W-1:0] r_bits_left;
   logic [CNT_W-1:0] w_rem;
   logic             r_shift_en;
   logic             r_cfg_done;
   logic             w_start_ok;
   logic             w_final;
   logic             w_xfer;
   logic             w_last;
   logic             w_head;
   logic             w_clear;
   logic             w_load;
   logic             w_advance;
   logic [NB_W-1:0]  w_nbits;
   ccff_byte_serializer u_ser (
      .prog_clk (prog_clk),
      .pReset   (pReset),
      .i_clear  (w_clear),
      .i_load   (w_load),
      .i_advance(w_advance),
      .i_din    (bus.din),
      .i_nbits  (w_nbits),
      .o_head   (w_head),
      .o_last   (w_last)
   );
   always_ff @(posedge prog_clk or negedge pReset)
      if (!pReset) r_state <= IDLE;
      else r_state <= w_state_nx;
   always_comb
      w_state_nx = bus.abort ? IDLE :
                   w_start_ok ? LOAD :
                   (r_state == LOAD && w_xfer) ? SHIFT :
                   (r_state == SHIFT && w_last) ? (w_final ? DONE : w_xfer ? SHIFT : LOAD) :
                   r_state;
   always_comb begin
      w_start_ok    = bus.start && (r_state == IDLE || r_state == DONE);
      // w_final: the bit on the head now is the last bit of the whole chain
      w_final       = r_state == SHIFT && w_last && r_bits_left == CNT_W'(1);
      // Ready in the last bit of a byte so the next byte follows without a bubble;
      // withheld during abort so the source never sees a byte accepted and then lost.
      bus.din_ready = !bus.abort && (r_state == LOAD || (r_state == SHIFT && w_last && !w_final));
      w_xfer        = bus.din_valid && bus.din_ready;
      bus.busy      = r_state == LOAD || r_state == SHIFT;
      // Bits remaining once the current head bit is gone; sizes the byte being accepted.
      w_rem         = r_state == SHIFT ? r_bits_left - CNT_W'(1) : r_bits_left;
      w_nbits       = 32'(w_rem) >= BYTE_W ? NB_W'(BYTE_W) : NB_W'(w_rem);
      w_clear       = bus.abort || w_start_ok;
      w_load        = w_xfer;
      w_advance     = r_state == SHIFT;
   end
   // shift_en and cfg_done are dedicated flops so the fabric clock gate sees a clean enable.
   always_ff @(posedge prog_clk or negedge pReset)
      if (!pReset) begin
         r_shift_en  <= 1'b0;
         r_cfg_done  <= 1'b0;
         r_bits_left <= '0;
      end else begin
         r_shift_en  <= w_state_nx == SHIFT;
         r_cfg_done  <= w_state_nx == DONE;
         r_bits_left <= bus.abort ? '0 :
                        w_start_ok ? CNT_W'(CHAIN_LEN) :
                        (r_state == SHIFT && r_bits_left != '0) ? r_bits_left - CNT_W'(1) :
                        r_bits_left;
      end
   assign bus.ccff_head     = w_head;
   assign bus.ccff_shift_en = r_shift_en;
   assign bus.cfg_done      = r_cfg_done;
   assign bus.bits_left     = r_bits_left;
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb_ccff_bitstream_loader: directed scoreboard bench for 16-bit and 12-bit chain loaders
module tb_ccff_bitstream_loader;
   logic prog_clk = 1'b0;
   logic pReset   = 1'b0;
   always #5 prog_clk = ~prog_clk;
   ccff_bitstream_loader_if #(.CNT_W(5)) b16();
   ccff_bitstream_loader_if #(.CNT_W(4)) b12();
   ccff_bitstream_loader #(.CHAIN_LEN(16)) dut16 (.prog_clk(prog_clk), .pReset(pReset), .bus(b16));
   ccff_bitstream_loader #(.CHAIN_LEN(12)) dut12 (.prog_clk(prog_clk), .pReset(pReset), .bus(b12));
   int   n_assert = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   logic q16[$];
   logic q12[$];
   int   p16, p12, sh16, sh12, first16, last16, dc, bl;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // Advance one clock and score every chain output against the expected-bit queues.
   task automatic tick();
      @(posedge prog_clk);
      @(negedge prog_clk);
      cyc++;
      if (b16.ccff_shift_en) begin
         sh16++;
         if (first16 < 0) first16 = cyc;
         last16 = cyc;
         chk("bl16_nonzero_on_shift", 32'(b16.bits_left != 0), 1);
         chk("sb16_has_bit", 32'(q16.size() != 0), 1);
         if (q16.size() != 0) chk("head16", 32'(b16.ccff_head), 32'(q16.pop_front()));
      end else chk("head16_quiet", 32'(b16.ccff_head), 0);
      if (b12.ccff_shift_en) begin
         sh12++;
         chk("bl12_nonzero_on_shift", 32'(b12.bits_left != 0), 1);
         chk("sb12_has_bit", 32'(q12.size() != 0), 1);
         if (q12.size() != 0) chk("head12", 32'(b12.ccff_head), 32'(q12.pop_front()));
      end else chk("head12_quiet", 32'(b12.ccff_head), 0);
   endtask
   task automatic start16();
      q16.delete(); p16 = 0; sh16 = 0; first16 = -1;
      b16.start = 1'b1; tick(); b16.start = 1'b0;
   endtask
   task automatic start12();
      q12.delete(); p12 = 0; sh12 = 0;
      b12.start = 1'b1; tick(); b12.start = 1'b0;
   endtask
   task automatic send16(input logic [7:0] b);
      bit ok = 0;
      for (int i = 7; i >= 0; i--) if (p16 < 16) begin q16.push_back(b[i]); p16++; end
      b16.din = b; b16.din_valid = 1'b1;
      for (int t = 0; t < 60; t++) begin
         #1;
         ok = b16.din_ready;
         tick();
         if (ok) break;
      end
      b16.din_valid = 1'b0;
      chk("send16_accepted", 32'(ok), 1);
   endtask
   task automatic send12(input logic [7:0] b);
      bit ok = 0;
      for (int i = 7; i >= 0; i--) if (p12 < 12) begin q12.push_back(b[i]); p12++; end
      b12.din = b; b12.din_valid = 1'b1;
      for (int t = 0; t < 60; t++) begin
         #1;
         ok = b12.din_ready;
         tick();
         if (ok) break;
      end
      b12.din_valid = 1'b0;
      chk("send12_accepted", 32'(ok), 1);
   endtask
   task automatic wait_done16();
      bit ok = 0;
      for (int t = 0; t < 80 && !ok; t++) begin tick(); ok = b16.cfg_done; end
      chk("done16_seen", 32'(ok), 1);
      dc = cyc;
   endtask
   task automatic wait_done12();
      bit ok = 0;
      for (int t = 0; t < 80 && !ok; t++) begin tick(); ok = b12.cfg_done; end
      chk("done12_seen", 32'(ok), 1);
   endtask
   task automatic chk_idle16(input string tag);
      chk({tag, "_shift_en"}, 32'(b16.ccff_shift_en), 0);
      chk({tag, "_head"}, 32'(b16.ccff_head), 0);
      chk({tag, "_busy"}, 32'(b16.busy), 0);
      chk({tag, "_cfg_done"}, 32'(b16.cfg_done), 0);
      chk({tag, "_bits_left"}, 32'(b16.bits_left), 0);
      chk({tag, "_din_ready"}, 32'(b16.din_ready), 0);
   endtask
   initial begin
      bit ok;
      b16.start = 0; b16.abort = 0; b16.din = 0; b16.din_valid = 0;
      b12.start = 0; b12.abort = 0; b12.din = 0; b12.din_valid = 0;
      first16 = -1;
      repeat (3) tick();
      chk_idle16("reset");
      chk("reset12_bits_left", 32'(b12.bits_left), 0);
      pReset = 1'b1;
      tick();
      // Two full bytes, valid held high, gapless
      start16();
      chk("t1_busy", 32'(b16.busy), 1);
      chk("t1_bits_left", 32'(b16.bits_left), 16);
      chk("t1_ready", 32'(b16.din_ready), 1);
      send16(8'hA5);
      send16(8'h3C);
      wait_done16();
      chk("t1_shift_count", 32'(sh16), 16);
      chk("t1_contiguous", 32'(last16 - first16 + 1), 16);
      chk("t1_done_cycle", 32'(dc), 32'(last16 + 1));
      chk("t1_sb_empty", 32'(q16.size()), 0);
      chk("t1_ready_done", 32'(b16.din_ready), 0);
      chk("t1_bits_left_done", 32'(b16.bits_left), 0);
      chk("t1_busy_done", 32'(b16.busy), 0);
      // Partial final byte on the 12-bit chain
      start12();
      send12(8'hFF);
      send12(8'hF0);
      wait_done12();
      chk("t2_shift_count", 32'(sh12), 12);
      chk("t2_sb_empty", 32'(q12.size()), 0);
      b12.din = 8'hAA; b12.din_valid = 1'b1;
      repeat (3) begin
         #1 chk("t2_ready_done", 32'(b12.din_ready), 0);
         tick();
      end
      b12.din_valid = 1'b0;
      chk("t2_cfg_done_held", 32'(b12.cfg_done), 1);
      chk("t2_shift_count_after", 32'(sh12), 12);
      // Restart from DONE, ignored start mid-shift, valid gap between bytes
      chk("t6_done_before", 32'(b16.cfg_done), 1);
      start16();
      chk("t6_done_cleared", 32'(b16.cfg_done), 0);
      chk("t6_bits_left_reload", 32'(b16.bits_left), 16);
      chk("t6_ready_load", 32'(b16.din_ready), 1);
      send16(8'hA5);
      bl = b16.bits_left;
      b16.start = 1'b1; tick(); b16.start = 1'b0;
      chk("t6_start_ignored_bits_left", 32'(b16.bits_left), 32'(bl - 1));
      chk("t6_start_ignored_busy", 32'(b16.ccff_shift_en), 1);
      ok = 0;
      for (int t = 0; t < 20 && !ok; t++) begin
         if (!b16.ccff_shift_en) ok = 1;
         else tick();
      end
      chk("t3_byte_drained", 32'(ok), 1);
      repeat (5) begin
         chk("t3_gap_shift_en", 32'(b16.ccff_shift_en), 0);
         chk("t3_gap_busy", 32'(b16.busy), 1);
         tick();
      end
      chk("t3_bits_left_gap", 32'(b16.bits_left), 8);
      send16(8'h3C);
      wait_done16();
      chk("t3_shift_count", 32'(sh16), 16);
      chk("t3_sb_empty", 32'(q16.size()), 0);
      // Abort after five shifted bits
      start16();
      send16(8'hA5);
      repeat (4) tick();
      chk("t4_shifts_before_abort", 32'(sh16), 5);
      b16.abort = 1'b1; tick(); b16.abort = 1'b0;
      chk_idle16("t4_abort");
      q16.delete();
      start16();
      chk("t4_restart_bits_left", 32'(b16.bits_left), 16);
      // Asynchronous reset mid-shift
      send16(8'h81);
      tick();
      #2 pReset = 1'b0;
      #1 chk_idle16("t5_async_reset");
      q16.delete();
      b16.start = 1'b1;
      tick();
      chk("t5_start_in_reset_busy", 32'(b16.busy), 0);
      chk("t5_start_in_reset_bits_left", 32'(b16.bits_left), 0);
      b16.start = 1'b0;
      pReset = 1'b1;
      tick();
      chk_idle16("t5_after_release");
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
